// File: rtl/clk_div_pkg.sv
// Shared constants and divisor clamp for the programmable clock divider.
package clk_div_pkg;

    localparam int MIN_DIV      = 2;
    localparam int DEF_CLK_FREQ = 10000000;

    // Keep the low `width` bits, then force the result up to MIN_DIV.
    function automatic logic [63:0] div_sanitise(
        input logic [63:0] value,
        input int          width
    );
        logic [63:0] m;
        m = value & ((64'd1 << width) - 64'd1);
        if (m < 64'(MIN_DIV)) begin
            m = 64'(MIN_DIV);
        end
        return m;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter: start/wrap/restart detection and clk_o/tick_o decode.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 26
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_start,
    output logic             o_clk,
    output logic             o_tick
);

    logic             r_run;
    logic [CNT_W-1:0] r_k;
    logic             r_clk;
    logic             r_tick;

    logic             w_last;
    logic [CNT_W-1:0] w_k_inc;
    logic             w_start;

    assign w_last  = (r_k == i_div - 1'b1);
    assign w_k_inc = r_k + 1'b1;
    assign w_start = i_en & (~r_run | i_sync | w_last);

    // A new period always begins high: k = 0 < N/2 since N >= 2.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_run  <= 1'b0;
            r_k    <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else if (!i_en) begin
            r_run  <= 1'b0;
            r_k    <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else if (w_start) begin
            r_run  <= 1'b1;
            r_k    <= '0;
            r_clk  <= 1'b1;
            r_tick <= 1'b1;
        end else begin
            r_k    <= w_k_inc;
            r_clk  <= (w_k_inc < (i_div >> 1));
            r_tick <= 1'b0;
        end
    end

    assign o_start = w_start;
    assign o_clk   = r_clk;
    assign o_tick  = r_tick;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable divider top: pending divisor, load/apply handshake, upd_o/div_o.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 26,
    parameter int DIV_RST = DEF_CLK_FREQ
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             upd_o,
    output logic [CNT_W-1:0] div_o
);

    localparam logic [CNT_W-1:0] L_DIV_RST =
        CNT_W'(div_sanitise(64'(DIV_RST), CNT_W));

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_upd;

    logic [CNT_W-1:0] w_div_san;
    logic [CNT_W-1:0] w_div_next;
    logic             w_start;

    assign w_div_san = CNT_W'(div_sanitise(64'(div_i), CNT_W));

    // A load coinciding with a period start bypasses the pending slot.
    assign w_div_next = load_i ? w_div_san :
                        (r_pend ? r_pend_div : r_div);

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .i_clk   (clk_i),
        .i_rst   (rst),
        .i_en    (en_i),
        .i_sync  (sync_i),
        .i_div   (r_div),
        .o_start (w_start),
        .o_clk   (clk_o),
        .o_tick  (tick_o)
    );

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_div      <= L_DIV_RST;
            r_pend_div <= L_DIV_RST;
            r_pend     <= 1'b0;
            r_upd      <= 1'b0;
        end else begin
            r_upd <= w_start & (load_i | r_pend);
            if (w_start) begin
                r_div  <= w_div_next;
                r_pend <= 1'b0;
            end else if (load_i) begin
                r_pend_div <= w_div_san;
                r_pend     <= 1'b1;
            end
        end
    end

    assign upd_o = r_upd;
    assign div_o = r_div;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed vector bench for clk_div_prog with DIV_RST = 4.
module tb_clk_div_prog;

    localparam int CNT_W = 26;

    logic             clk_i;
    logic             rst;
    logic             en_i;
    logic             sync_i;
    logic             load_i;
    logic [CNT_W-1:0] div_i;
    logic             clk_o;
    logic             tick_o;
    logic             upd_o;
    logic [CNT_W-1:0] div_o;

    int errors;
    int checks;

    typedef struct {
        logic             en;
        logic             sync;
        logic             load;
        logic [CNT_W-1:0] div;
        logic             c;
        logic             t;
        logic             u;
        logic [CNT_W-1:0] d;
    } vec_t;

    vec_t vq[$];

    clk_div_prog #(
        .CNT_W   (CNT_W),
        .DIV_RST (4)
    ) dut (
        .clk_i  (clk_i),
        .rst    (rst),
        .en_i   (en_i),
        .sync_i (sync_i),
        .load_i (load_i),
        .div_i  (div_i),
        .clk_o  (clk_o),
        .tick_o (tick_o),
        .upd_o  (upd_o),
        .div_o  (div_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d",
                     nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic c, input logic t,
                           input logic u, input logic [CNT_W-1:0] d);
        chk("clk_o", idx, 32'(clk_o), 32'(c));
        chk("tick_o", idx, 32'(tick_o), 32'(t));
        chk("upd_o", idx, 32'(upd_o), 32'(u));
        chk("div_o", idx, 32'(div_o), 32'(d));
    endtask

    task automatic add(input logic en, input logic sy, input logic ld,
                       input int dv, input logic c, input logic t,
                       input logic u, input int d);
        vec_t v;
        v.en   = en;
        v.sync = sy;
        v.load = ld;
        v.div  = CNT_W'(dv);
        v.c    = c;
        v.t    = t;
        v.u    = u;
        v.d    = CNT_W'(d);
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        en_i   = 1'b0;
        sync_i = 1'b0;
        load_i = 1'b0;
        div_i  = '0;

        // Default divisor 4: 1,1,0,0 repeating
        add(0,0,0,0, 0,0,0,4);
        add(1,0,0,0, 1,1,0,4);
        add(1,0,0,0, 1,0,0,4);
        add(1,0,0,0, 0,0,0,4);
        add(1,0,0,0, 0,0,0,4);
        add(1,0,0,0, 1,1,0,4);
        add(1,0,0,0, 1,0,0,4);
        add(1,0,0,0, 0,0,0,4);
        add(1,0,0,0, 0,0,0,4);
        add(0,0,0,0, 0,0,0,4);
        // Odd divisor loaded while idle
        add(0,0,1,5, 0,0,0,4);
        add(1,0,0,0, 1,1,1,5);
        add(1,0,0,0, 1,0,0,5);
        add(1,0,0,0, 0,0,0,5);
        add(1,0,0,0, 0,0,0,5);
        add(1,0,0,0, 0,0,0,5);
        add(1,0,0,0, 1,1,0,5);
        add(0,0,0,0, 0,0,0,5);
        // Clamp 0 then 1 -> 2
        add(0,0,1,0, 0,0,0,5);
        add(1,0,0,0, 1,1,1,2);
        add(1,0,0,0, 0,0,0,2);
        add(1,0,0,0, 1,1,0,2);
        add(1,0,1,1, 0,0,0,2);
        add(1,0,0,0, 1,1,1,2);
        add(1,0,0,0, 0,0,0,2);
        add(0,0,0,0, 0,0,0,2);
        // N=8, load 3 at k=2, load 6 at k=4
        add(0,0,1,8, 0,0,0,2);
        add(1,0,0,0, 1,1,1,8);
        add(1,0,0,0, 1,0,0,8);
        add(1,0,0,0, 1,0,0,8);
        add(1,0,1,3, 1,0,0,8);
        add(1,0,0,0, 0,0,0,8);
        add(1,0,1,6, 0,0,0,8);
        add(1,0,0,0, 0,0,0,8);
        add(1,0,0,0, 0,0,0,8);
        add(1,0,0,0, 1,1,1,6);
        add(1,0,0,0, 1,0,0,6);
        add(1,0,0,0, 1,0,0,6);
        add(1,0,0,0, 0,0,0,6);
        add(1,0,0,0, 0,0,0,6);
        add(1,0,0,0, 0,0,0,6);
        add(1,0,0,0, 1,1,0,6);
        // N=4, load 2 at k=3 applies immediately
        add(0,0,0,0, 0,0,0,6);
        add(0,0,1,4, 0,0,0,6);
        add(1,0,0,0, 1,1,1,4);
        add(1,0,0,0, 1,0,0,4);
        add(1,0,0,0, 0,0,0,4);
        add(1,0,0,0, 0,0,0,4);
        add(1,0,1,2, 1,1,1,2);
        add(1,0,0,0, 0,0,0,2);
        add(1,0,0,0, 1,1,0,2);
        // N=10: sync at k=5, stop at k=3
        add(0,0,0,0, 0,0,0,2);
        add(0,0,1,10, 0,0,0,2);
        add(1,0,0,0, 1,1,1,10);
        add(1,0,0,0, 1,0,0,10);
        add(1,0,0,0, 1,0,0,10);
        add(1,0,0,0, 1,0,0,10);
        add(1,0,0,0, 1,0,0,10);
        add(1,0,0,0, 0,0,0,10);
        add(1,1,0,0, 1,1,0,10);
        add(1,0,0,0, 1,0,0,10);
        add(1,0,0,0, 1,0,0,10);
        add(1,0,0,0, 1,0,0,10);
        add(0,0,0,0, 0,0,0,10);
        add(1,0,0,0, 1,1,0,10);
        add(1,0,0,0, 1,0,0,10);
        // load with sync applies to restarted period
        add(1,1,1,3, 1,1,1,3);
        add(1,0,0,0, 0,0,0,3);
        add(1,0,0,0, 0,0,0,3);
        add(1,0,0,0, 1,1,0,3);
        // sync while idle is ignored
        add(0,0,0,0, 0,0,0,3);
        add(0,1,0,0, 0,0,0,3);
        // run with a pending load, then reset mid-period
        add(1,0,0,0, 1,1,0,3);
        add(1,0,1,7, 0,0,0,3);

        #3;
        chk_all(-1, 1'b0, 1'b0, 1'b0, CNT_W'(4));
        @(negedge clk_i);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            en_i   = vq[i].en;
            sync_i = vq[i].sync;
            load_i = vq[i].load;
            div_i  = vq[i].div;
            step();
            chk_all(i, vq[i].c, vq[i].t, vq[i].u, vq[i].d);
        end

        // Async reset mid-period discards pending 7
        en_i   = 1'b1;
        sync_i = 1'b0;
        load_i = 1'b0;
        div_i  = '0;
        step();
        chk_all(1000, 1'b0, 1'b0, 1'b0, CNT_W'(3));
        #2;
        rst = 1'b1;
        #1;
        chk_all(1001, 1'b0, 1'b0, 1'b0, CNT_W'(4));
        #2;
        rst = 1'b0;
        step();
        chk_all(1002, 1'b1, 1'b1, 1'b0, CNT_W'(4));
        step();
        chk_all(1003, 1'b1, 1'b0, 1'b0, CNT_W'(4));
        step();
        chk_all(1004, 1'b0, 1'b0, 1'b0, CNT_W'(4));
        step();
        chk_all(1005, 1'b0, 1'b0, 1'b0, CNT_W'(4));
        step();
        chk_all(1006, 1'b1, 1'b1, 1'b0, CNT_W'(4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
